// File: rtl/ram_latch_arbiter.sv
// Two-port round-robin arbiter and setup/strobe/hold sequencer for a latch-based RAM array.
// Every array control line comes straight from a flop, so the latches never see glitches or s = r = 1.
module ram_latch_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_s,
    output logic [DW-1:0] ram_r,
    output logic          ram_en,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t r_state;
    logic   r_we;
    logic   r_gnt;
    logic   r_last;

    logic          w_pick1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wd;

    // Port 1 wins when alone, or when both request and port 0 was granted last.
    assign w_pick1 = req1 & (~req0 | ~r_last);
    assign w_we    = w_pick1 ? we1    : we0;
    assign w_addr  = w_pick1 ? addr1  : addr0;
    assign w_wd    = w_pick1 ? wdata1 : wdata0;

    // NOTE: all state and outputs are flops updated with <=, so every branch
    // reads the pre-edge values and no ordering hazards exist between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            ram_addr <= '0;
            ram_s    <= '0;
            ram_r    <= '0;
            ram_en   <= 1'b0;
            ram_rd   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_gnt    <= w_pick1;
                        r_last   <= w_pick1;
                        r_we     <= w_we;
                        busy     <= 1'b1;
                        // ram_addr/ram_s/ram_r double as the captured address and data.
                        ram_addr <= w_addr;
                        ram_s    <= w_we ? w_wd  : '0;
                        ram_r    <= w_we ? ~w_wd : '0;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    ram_en  <= r_we;
                    ram_rd  <= ~r_we;
                    r_state <= STROBE;
                end
                STROBE: begin
                    ram_en <= 1'b0;
                    ram_rd <= 1'b0;
                    if (!r_we) begin
                        rdata <= ram_q;
                    end
                    ack0    <= ~r_gnt;
                    ack1    <= r_gnt;
                    r_state <= HOLD;
                end
                HOLD: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    ram_s   <= '0;
                    ram_r   <= '0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_latch_arbiter.sv
// Directed bench for ram_latch_arbiter: behavioural latch array, scoreboard of expected
// acknowledges (port, cycle, read data) and a per-cycle invariant monitor.
module tb_ram_latch_arbiter;

    typedef struct {
        bit         port;
        bit         rd;
        logic [7:0] data;
        int         exp_cyc;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, ram_addr;
    logic [7:0] wdata0, wdata1, rdata, ram_s, ram_r, ram_q;
    logic       ack0, ack1, busy, ram_en, ram_rd;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] shadow [16];
    sb_t        sb [$];

    ram_latch_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_s(ram_s), .ram_r(ram_r),
        .ram_en(ram_en), .ram_rd(ram_rd), .ram_q(ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Latch array: the enabled word follows set/reset while ram_en is high.
    always @(negedge clk) if (ram_en) mem[ram_addr] <= (mem[ram_addr] | ram_s) & ~ram_r;
    assign ram_q = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("s_and_r", 32'(ram_s & ram_r), 32'd0);
            chk("en_and_rd", 32'(ram_en & ram_rd), 32'd0);
            chk("ack_both", 32'(ack0 & ack1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 8 && busy; i++) tick();
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic set_port(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (!p) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic push(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d, input int lat);
        sb_t e;
        e.port    = p;
        e.rd      = !we;
        e.data    = we ? d : shadow[a];
        e.exp_cyc = cyc + lat;
        sb.push_back(e);
        if (we) shadow[a] = d;
    endtask

    task automatic drive(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
        wait_idle();
        set_port(p, we, a, d);
        push(p, we, a, d, 3);
    endtask

    task automatic collect(input bit drop);
        bit  got;
        sb_t e;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = ack0 | ack1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (got) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
                chk("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
                if (e.rd) chk("rdata", 32'(rdata), 32'(e.data));
                if (drop) begin
                    if (e.port) req1 = 1'b0;
                    else        req0 = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ack0"}, 32'(ack0), 32'd0);
        chk({tag, "_ack1"}, 32'(ack1), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_rd"}, 32'(ram_rd), 32'd0);
        chk({tag, "_ram_s"}, 32'(ram_s), 32'd0);
        chk({tag, "_ram_r"}, 32'(ram_r), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         p;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_all_zero("reset");

        // Contention from reset: port 0 first, then port 1 while port 0 re-requests, then port 0.
        set_port(1'b0, 1'b1, 4'd5, 8'h11);
        set_port(1'b1, 1'b1, 4'd6, 8'h22);
        push(1'b0, 1'b1, 4'd5, 8'h11, 3);
        push(1'b1, 1'b1, 4'd6, 8'h22, 7);
        push(1'b0, 1'b1, 4'd5, 8'h11, 11);
        collect(1'b0);
        collect(1'b1);
        collect(1'b1);

        // Port 0 writes A5 to address 3 with cycle-by-cycle array checks.
        drive(1'b0, 1'b1, 4'd3, 8'hA5);
        tick();
        chk("setup_busy", 32'(busy), 32'd1);
        chk("setup_en", 32'(ram_en), 32'd0);
        chk("setup_s", 32'(ram_s), 32'hA5);
        chk("setup_r", 32'(ram_r), 32'h5A);
        chk("setup_addr", 32'(ram_addr), 32'd3);
        tick();
        chk("strobe_en", 32'(ram_en), 32'd1);
        chk("strobe_rd", 32'(ram_rd), 32'd0);
        chk("strobe_ack0", 32'(ack0), 32'd0);
        collect(1'b1);
        chk("hold_en", 32'(ram_en), 32'd0);
        chk("hold_s", 32'(ram_s), 32'hA5);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_s", 32'(ram_s), 32'd0);
        chk("idle_r", 32'(ram_r), 32'd0);
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        collect(1'b1);

        // Port 0 holds a read request: back-to-back acks every 4 cycles.
        wait_idle();
        set_port(1'b0, 1'b0, 4'd5, 8'h00);
        push(1'b0, 1'b0, 4'd5, 8'h00, 3);
        push(1'b0, 1'b0, 4'd5, 8'h00, 7);
        push(1'b0, 1'b0, 4'd5, 8'h00, 11);
        collect(1'b0);
        collect(1'b0);
        collect(1'b1);

        // Inputs changed during SETUP must not affect the captured write.
        drive(1'b0, 1'b1, 4'd7, 8'h3C);
        tick();
        addr0 = 4'd8;
        wdata0 = 8'hFF;
        collect(1'b1);
        drive(1'b1, 1'b0, 4'd7, 8'h00);
        collect(1'b1);
        drive(1'b1, 1'b0, 4'd8, 8'h00);
        collect(1'b1);

        // Asynchronous reset in the middle of a write strobe.
        wait_idle();
        set_port(1'b0, 1'b1, 4'd9, 8'h77);
        tick();
        tick();
        chk("abort_strobe_en", 32'(ram_en), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        req0 = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_ack", 32'(ack0 | ack1), 32'd0);
        end
        drive(1'b0, 1'b0, 4'd7, 8'h00);
        tick();
        chk("post_reset_grant", 32'(busy), 32'd1);
        collect(1'b1);

        // Address sweep: random write then readback from the other port.
        for (int a = 0; a < 16; a++) begin
            p = a[0];
            d = 8'($urandom_range(0, 255));
            drive(p, 1'b1, 4'(a), d);
            collect(1'b1);
            drive(!p, 1'b0, 4'(a), 8'h00);
            collect(1'b1);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
